// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared types and helpers for the serial pattern generator and its
// consecutive-ones prediction model.
//   gen_state_t   : generator FSM encoding
//   PAT_W_DEFAULT : default maximum pattern length in bits
//   RUN_MAX       : saturation value of the ones-run counter
//   run_step()    : next value of the saturating ones-run counter
// -----------------------------------------------------------------------------
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } gen_state_t;

  localparam int PAT_W_DEFAULT = 16;

  // Two consecutive ones are all the recognizer needs to see.
  localparam logic [1:0] RUN_MAX = 2'd2;

  // A sampled one extends the run up to RUN_MAX; anything else clears it.
  function automatic logic [1:0] run_step(input logic [1:0] run, input logic one);
    logic [1:0] nxt;
    if (!one) begin
      nxt = 2'd0;
    end else if (run >= RUN_MAX) begin
      nxt = RUN_MAX;
    end else begin
      nxt = run + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ones_run_tracker.sv
// -----------------------------------------------------------------------------
// ones_run_tracker
// Golden model of the consecutive-ones recognizer: counts consecutive sampled
// ones (d_valid && d), saturating at two, and flags a run of two or more.
// Ports:
//   clk      in  clock, posedge
//   reset    in  synchronous, active-high; clears the run counter
//   d        in  serial data
//   d_valid  in  d carries a pattern bit (d_valid=0 is treated as d=0)
//   expect_q out high while the registered run count has reached two
// -----------------------------------------------------------------------------
module ones_run_tracker
  import pattern_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic d_valid,
  output logic expect_q
);

  logic [1:0] run_r;

  // Saturating run counter of consecutive valid ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_r <= 2'd0;
    end else begin
      run_r <= run_step(run_r, d_valid && d);
    end
  end

  assign expect_q = (run_r == RUN_MAX);

endmodule

// File: rtl/pattern_generator.sv
// -----------------------------------------------------------------------------
// pattern_generator
// Bit-serial stimulus source. Accepts a pattern descriptor over valid/ready and
// shifts the pattern out MSB-first on d, repeated (repeat+1) times with
// zero-filled gaps in between, then pulses done for one cycle. expect_q is the
// cycle-exact prediction of the downstream consecutive-ones recognizer.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   load_valid     descriptor offered
//   load_ready     idle and not in reset; descriptor accepted on valid&&ready
//   load_pattern   pattern bits, [len-1:0] used, bit len-1 sent first
//   load_len       pattern length; 0 or >PAT_W means PAT_W
//   load_repeat    extra repetitions
//   load_gap       idle cycles between repetitions
//   d, d_valid     registered serial output and its qualifier
//   busy           descriptor in progress
//   done           one-cycle pulse after the final bit
//   expect_q       predicted recognizer output
// -----------------------------------------------------------------------------
module pattern_generator
  import pattern_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int REP_W = 4,
  parameter int GAP_W = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] load_pattern,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_repeat,
  input  logic [GAP_W-1:0] load_gap,
  output logic             d,
  output logic             d_valid,
  output logic             busy,
  output logic             done,
  output logic             expect_q
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  gen_state_t       state_r,   state_s;
  logic [PAT_W-1:0] pat_r,     pat_s;
  logic [LEN_W-1:0] len_r,     len_s;
  logic [GAP_W-1:0] gap_r,     gap_s;
  logic [LEN_W-1:0] idx_r,     idx_s;
  logic [REP_W-1:0] rep_r,     rep_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;

  logic d_r,       d_s;
  logic d_valid_r, d_valid_s;
  logic busy_r,    busy_s;
  logic done_r,    done_s;

  logic             fire_s;
  logic [LEN_W-1:0] len_clamped_s;

  assign load_ready = (state_r == IDLE) && !reset;
  assign fire_s     = load_valid && load_ready;

  // Out-of-range lengths fall back to the full pattern width, so idx never
  // starts beyond the pattern register and len-1 never underflows.
  always_comb begin
    len_clamped_s = load_len;
    if ((load_len == LEN_W'(0)) || (load_len > PAT_W_L)) begin
      len_clamped_s = PAT_W_L;
    end else begin
      len_clamped_s = load_len;
    end
  end

  // Next-state logic for the FSM and its idx / repeat / gap counters.
  always_comb begin
    state_s   = state_r;
    pat_s     = pat_r;
    len_s     = len_r;
    gap_s     = gap_r;
    idx_s     = idx_r;
    rep_s     = rep_r;
    gap_cnt_s = gap_cnt_r;
    case (state_r)
      IDLE: begin
        if (fire_s) begin
          state_s   = SHIFT;
          pat_s     = load_pattern;
          len_s     = len_clamped_s;
          gap_s     = load_gap;
          idx_s     = len_clamped_s - LEN_W'(1);
          rep_s     = load_repeat;
          gap_cnt_s = load_gap;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (idx_r != LEN_W'(0)) begin
          idx_s = idx_r - LEN_W'(1);
        end else if (rep_r == REP_W'(0)) begin
          state_s = DONE;
        end else if (gap_r != GAP_W'(0)) begin
          state_s   = GAP;
          gap_cnt_s = gap_r;
        end else begin
          // Back-to-back repeat: restart the pattern without an idle cycle.
          idx_s = len_r - LEN_W'(1);
          rep_s = rep_r - REP_W'(1);
        end
      end
      GAP: begin
        // gap_cnt_r counts the gap cycles still to be spent, including this one.
        if (gap_cnt_r <= GAP_W'(1)) begin
          state_s = SHIFT;
          idx_s   = len_r - LEN_W'(1);
          rep_s   = rep_r - REP_W'(1);
        end else begin
          gap_cnt_s = gap_cnt_r - GAP_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so that the
  // registered outputs line up with the state they describe.
  always_comb begin
    d_s       = 1'b0;
    d_valid_s = 1'b0;
    busy_s    = (state_s != IDLE);
    done_s    = (state_s == DONE);
    if (state_s == SHIFT) begin
      d_valid_s = 1'b1;
      d_s       = |(pat_s & (PAT_W'(1) << idx_s));
    end else begin
      d_valid_s = 1'b0;
      d_s       = 1'b0;
    end
  end

  // State, descriptor, counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      pat_r     <= '0;
      len_r     <= '0;
      gap_r     <= '0;
      idx_r     <= '0;
      rep_r     <= '0;
      gap_cnt_r <= '0;
      d_r       <= 1'b0;
      d_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      pat_r     <= pat_s;
      len_r     <= len_s;
      gap_r     <= gap_s;
      idx_r     <= idx_s;
      rep_r     <= rep_s;
      gap_cnt_r <= gap_cnt_s;
      d_r       <= d_s;
      d_valid_r <= d_valid_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign d       = d_r;
  assign d_valid = d_valid_r;
  assign busy    = busy_r;
  assign done    = done_r;

  // The prediction is taken from exactly what leaves this block.
  ones_run_tracker u_tracker (
    .clk      (clk),
    .reset    (reset),
    .d        (d_r),
    .d_valid  (d_valid_r),
    .expect_q (expect_q)
  );

endmodule

// File: tb/tb_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_pattern_generator
// Directed stimulus with hand-written per-cycle expected traces. The stimulus
// process pushes one expected output vector per cycle into a scoreboard queue;
// a monitor on the falling edge pops and compares entries due in that cycle.
// Vector order: {load_ready, busy, d_valid, d, done, expect_q}.
// -----------------------------------------------------------------------------
module tb_pattern_generator;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_pattern;
  logic [4:0]  load_len;
  logic [3:0]  load_repeat;
  logic [3:0]  load_gap;
  logic        d;
  logic        d_valid;
  logic        busy;
  logic        done;
  logic        expect_q;

  typedef struct {
    int          cyc;
    logic [5:0]  exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cur;

  pattern_generator dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_len     (load_len),
    .load_repeat  (load_repeat),
    .load_gap     (load_gap),
    .d            (d),
    .d_valid      (d_valid),
    .busy         (busy),
    .done         (done),
    .expect_q     (expect_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic bitc(input byte c);
    return (c == 8'h31);
  endfunction

  // Cycle k (1-based) of a trace is the cycle whose counter value is base+k.
  task automatic push_trace(input string name, input int base,
                            input string rdy, input string bsy, input string dv,
                            input string dd, input string dn, input string q);
    for (int k = 0; k < dd.len(); k++) begin
      exp_t e;
      e.cyc  = base + 1 + k;
      e.exp  = {bitc(rdy[k]), bitc(bsy[k]), bitc(dv[k]), bitc(dd[k]), bitc(dn[k]), bitc(q[k])};
      e.name = $sformatf("%s_c%0d", name, k + 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] p, input logic [4:0] l,
                         input logic [3:0] r, input logic [3:0] g, output int c);
    load_pattern = p;
    load_len     = l;
    load_repeat  = r;
    load_gap     = g;
    load_valid   = 1'b1;
    c            = cyc;
    @(posedge clk);
    #1;
    load_valid   = 1'b0;
  endtask

  // Scoreboard monitor: compare every entry due in the current cycle.
  always @(negedge clk) begin
    logic [5:0] act;
    exp_t       e;
    act = {load_ready, busy, d_valid, d, done, expect_q};
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_checks++;
      if (e.cyc < cyc) begin
        $display("FAIL %s: sample missed at cycle %0d (due %0d)", e.name, cyc, e.cyc);
      end else if (act !== e.exp) begin
        $display("FAIL %s: got rdy/busy/dv/d/done/q=%b, want %b", e.name, act, e.exp);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    reset        = 1'b1;
    load_valid   = 1'b0;
    load_pattern = 16'h0000;
    load_len     = 5'd0;
    load_repeat  = 4'd0;
    load_gap     = 4'd0;

    // Reset held over two edges: everything low, then ready once released.
    @(posedge clk);
    #1;
    push_trace("reset", 0, "01", "00", "00", "00", "00", "00");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single 4-bit pattern 1011.
    do_load(16'h000B, 5'd4, 4'd0, 4'd0, cur);
    push_trace("t2", cur, "000001", "111110", "111100", "101100", "000010", "000010");
    wait_cyc(7);

    // 2-bit 11, three sends, gap of 3.
    do_load(16'h0003, 5'd2, 4'd2, 4'd3, cur);
    push_trace("t3", cur, "00000000000001", "11111111111110", "11000110001100",
               "11000110001100", "00000000000010", "00100001000010");
    wait_cyc(15);

    // Length 0 clamps to 16 bits of ones.
    do_load(16'hFFFF, 5'd0, 4'd0, 4'd0, cur);
    push_trace("t4", cur, "000000000000000001", "111111111111111110",
               "111111111111111100", "111111111111111100",
               "000000000000000010", "001111111111111110");
    wait_cyc(19);

    // Reset during the third bit aborts without a done pulse.
    do_load(16'h000B, 5'd4, 4'd0, 4'd0, cur);
    push_trace("t5", cur, "000111", "111000", "111000", "101000", "000000", "000000");
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(4);

    // Second descriptor held valid while busy: taken only once idle again.
    load_pattern = 16'h000B;
    load_len     = 5'd4;
    load_repeat  = 4'd0;
    load_gap     = 4'd0;
    load_valid   = 1'b1;
    cur          = cyc;
    push_trace("t6", cur, "000001000001", "111110111110", "111100111100",
               "101100010100", "000010000010", "000010000000");
    wait_cyc(1);
    load_pattern = 16'h0005;
    wait_cyc(6);
    load_valid   = 1'b0;
    wait_cyc(8);

    if (sb_q.size() != 0) begin
      n_checks += sb_q.size();
      $display("FAIL drain: %0d expected entries never compared, want 0", sb_q.size());
      sb_q.delete();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
